seg7_scan_driver: RTL and testbench

Multiplexed multi-digit 7-segment display driver and the parametrised successor of the single-digit BCD decoder. It captures a packed NUM_DIGITS-nibble value and time-multiplexes it onto one shared segment bus, strobing one digit enable at a time. It supports leading-zero blanking, per-digit decimal points, selectable output polarity and optional hex glyphs. It sits between the timer datapath and the board's display pins.

---
 rtl/seg7_scan_driver.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Time-multiplexed multi-digit 7-segment display driver. Captures
//             a packed nibble value plus per-digit decimal points into shadow
//             registers and scans them onto one shared segment bus, enabling
//             one digit anode at a time. Supports leading-zero blanking and
//             selectable output polarity.
//  Ports    : clk        - system clock, all logic on its rising edge
//             reset      - synchronous active-high reset
//             value      - NUM_DIGITS packed nibbles, digit 0 in bits 3:0
//             dp_in      - decimal point per digit (1 = lit)
//             load       - capture value/dp_in into the shadow registers
//             blank_lz   - leading-zero blanking enable (live level)
//             seg        - segment bus {g,f,e,d,c,b,a}
//             dp         - decimal point of the active digit
//             an         - digit enables, one-hot when active
//             frame_done - one-cycle pulse when the scan wraps to digit 0
//  Options  : SEG7_HEX_EN defined -> nibbles 10-15 render A,b,C,d,E,F;
//             otherwise they render with all segments off.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      blank_lz,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic c_INV = (ACTIVE_LOW != 0);

    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_IDX_W-1:0]      r_digit_idx;
    logic [4*NUM_DIGITS-1:0] r_value_q;
    logic [NUM_DIGITS-1:0]   r_dp_q;
    logic                    r_wrap;

    logic                    w_adv;
    logic [4*NUM_DIGITS-1:0] w_shifted;
    logic [3:0]              w_nibble;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_an;
    logic                    w_dp;
    logic [6:0]              w_glyph;
    logic [6:0]              w_seg;

    assign w_adv = (r_cnt == c_CNT_LAST);

    // Scan state and shadow registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_digit_idx <= '0;
            r_value_q   <= '0;
            r_dp_q      <= '0;
            r_wrap      <= 1'b0;
        end else begin
            if (load) begin
                r_value_q <= value;
                r_dp_q    <= dp_in;
            end
            // Marks the state that follows a wrap back to digit 0, so the
            // output stage can pulse frame_done alongside digit 0 (but not
            // after reset, where digit 0 is reached without a wrap).
            r_wrap <= w_adv && (r_digit_idx == c_IDX_LAST);
            if (w_adv) begin
                r_cnt       <= '0;
                r_digit_idx <= (r_digit_idx == c_IDX_LAST) ? '0 : r_digit_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Shifting the active digit down to bit 0 gives both its nibble and,
    // via the remaining upper bits, the "all more-significant digits zero"
    // test used for leading-zero blanking.
    assign w_shifted = r_value_q >> {r_digit_idx, 2'b00};
    assign w_nibble  = w_shifted[3:0];
    assign w_blank   = blank_lz && (r_digit_idx != '0) && (w_shifted == '0);
    assign w_an      = NUM_DIGITS'(1) << r_digit_idx;
    assign w_dp      = |(r_dp_q & w_an);

    always_comb begin
        w_glyph = 7'h00;
        case (w_nibble)
            4'h0: w_glyph = 7'h3F;
            4'h1: w_glyph = 7'h06;
            4'h2: w_glyph = 7'h5B;
            4'h3: w_glyph = 7'h4F;
            4'h4: w_glyph = 7'h66;
            4'h5: w_glyph = 7'h6D;
            4'h6: w_glyph = 7'h7D;
            4'h7: w_glyph = 7'h07;
            4'h8: w_glyph = 7'h7F;
            4'h9: w_glyph = 7'h67;
`ifdef SEG7_HEX_EN
            4'hA: w_glyph = 7'h77;
            4'hB: w_glyph = 7'h7C;
            4'hC: w_glyph = 7'h39;
            4'hD: w_glyph = 7'h5E;
            4'hE: w_glyph = 7'h79;
            4'hF: w_glyph = 7'h71;
`else
            default: w_glyph = 7'h00;
`endif
        endcase
    end

    assign w_seg = w_blank ? 7'h00 : w_glyph;

    // Registered outputs with polarity applied last
    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= {7{c_INV}};
            dp         <= c_INV;
            an         <= {NUM_DIGITS{c_INV}};
            frame_done <= 1'b0;
        end else begin
            seg        <= w_seg ^ {7{c_INV}};
            dp         <= w_dp ^ c_INV;
            an         <= w_an ^ {NUM_DIGITS{c_INV}};
            frame_done <= r_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Scoreboard bench for seg7_scan_driver (4 digits, 4 clocks per
//             digit, active-low). A cycle-level reference model derives the
//             expected display from the elapsed-cycle count and the shadowed
//             value; a separate monitor pops and compares every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int AL = 1;
    localparam logic INV = (AL != 0);

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
    } out_t;

    out_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [6:0]  glyph [16];
    bit          window_on = 1'b0;
    int          fd_seen   = 0;

    seg7_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (S),
        .ACTIVE_LOW (AL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        glyph[0] = 7'h3F; glyph[1] = 7'h06; glyph[2] = 7'h5B; glyph[3] = 7'h4F;
        glyph[4] = 7'h66; glyph[5] = 7'h6D; glyph[6] = 7'h7D; glyph[7] = 7'h07;
        glyph[8] = 7'h7F; glyph[9] = 7'h67;
`ifdef SEG7_HEX_EN
        glyph[10] = 7'h77; glyph[11] = 7'h7C; glyph[12] = 7'h39;
        glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;
`else
        for (int k = 10; k < 16; k++) glyph[k] = 7'h00;
`endif
    end

    // Expected display for the state reached 'cyc' cycles after reset:
    // digit = floor(cyc / S) mod N; a frame wraps every S*N cycles.
    function automatic out_t model_out(int cyc, logic [15:0] v, logic [3:0] dq, logic blz);
        out_t        e;
        int          d;
        logic [15:0] upper;
        logic [6:0]  g;
        d     = (cyc / S) % N;
        upper = v >> (4 * d);
        g     = glyph[upper[3:0]];
        if (blz && d > 0 && upper == 16'h0) g = 7'h00;
        e.seg = g ^ {7{INV}};
        e.dp  = dq[d] ^ INV;
        e.an  = (4'b0001 << d) ^ {4{INV}};
        e.fd  = (cyc > 0) && (cyc % (S * N) == 0);
        return e;
    endfunction

    // Reference model: one expectation per clock edge
    initial begin : model
        int          m_cyc;
        logic [15:0] m_val;
        logic [3:0]  m_dp;
        out_t        e;
        m_cyc = 0;
        m_val = '0;
        m_dp  = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                e.seg = {7{INV}};
                e.dp  = INV;
                e.an  = {4{INV}};
                e.fd  = 1'b0;
                m_cyc = 0;
                m_val = '0;
                m_dp  = '0;
            end else begin
                e = model_out(m_cyc, m_val, m_dp, blank_lz);
                m_cyc++;
                if (load) begin
                    m_val = value;
                    m_dp  = dp_in;
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare mid-cycle, away from the active edge
    initial begin : monitor
        out_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({seg, dp, an, frame_done} !== e) begin
                    failures++;
                    $display("FAIL display t=%0t actual seg=%h dp=%b an=%h fd=%b required seg=%h dp=%b an=%h fd=%b",
                             $time, seg, dp, an, frame_done, e.seg, e.dp, e.an, e.fd);
                end
                if (window_on && frame_done === 1'b1) fd_seen++;
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : stim
        logic [15:0] mask;
        reset    = 1'b1;
        load     = 1'b0;
        blank_lz = 1'b0;
        value    = '0;
        dp_in    = '0;
        tick(3);
        reset = 1'b0;
        tick(10);

        // Scan 1234 with dp on digit 1; live inputs then change without load
        value = 16'h1234; dp_in = 4'b0010; load = 1'b1;
        tick();
        load  = 1'b0;
        value = 16'($urandom); dp_in = 4'($urandom);
        tick(40);

        // Reset held mid-scan
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(20);

        // Leading-zero blanking
        value = 16'h0007; dp_in = 4'b1000; load = 1'b1; blank_lz = 1'b1;
        tick();
        load = 1'b0;
        tick(20);
        blank_lz = 1'b0;
        tick(16);

        // Hex nibbles, unblanked then blanked
        value = 16'h00AF; dp_in = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        tick(16);
        blank_lz = 1'b1;
        tick(16);
        blank_lz = 1'b0;

        // Free-run frame window with a mid-frame load
        window_on = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i == 30) begin
                value = 16'($urandom);
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        window_on = 1'b0;
        load = 1'b0;
        checks++;
        if (fd_seen != 4) begin
            failures++;
            $display("FAIL frame_count actual=%0d required=4", fd_seen);
        end

        // Randomized traffic, including reset+load collisions
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(4, 0))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            value = 16'($urandom) & mask;
            dp_in = 4'($urandom);
            load  = ($urandom_range(5, 0) == 0);
            reset = ($urandom_range(63, 0) == 0);
            if ($urandom_range(15, 0) == 0) blank_lz = ~blank_lz;
            tick();
        end
        reset = 1'b0;
        load  = 1'b0;
        tick(4);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
